rv32m_muldiv_unit: RTL
======================

// Module: rv32m_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit for the execute stage, sitting beside the ALU.
//  Accepts one op_reg/funct7=0000001 instruction (funct3 selects the op), computes over XLEN cycles
//  and returns an XLEN-bit result. The EX stage stalls on ready_o/done_o; flush_i kills work in flight.
// PARAMETERS
//  XLEN  32  operand/result width; even, >=4; iteration counter width $clog2(XLEN)
// PORTS
//  clk       in   1     clock
//  rst       in   1     asynchronous, active-high reset
//  start_i   in   1     request; accepted only when ready_o=1
//  funct3_i  in   3     muldiv_funct3_t op, sampled on acceptance
//  a_i       in   XLEN  rs1 operand, sampled on acceptance
//  b_i       in   XLEN  rs2 operand, sampled on acceptance
//  flush_i   in   1     abort current op (pipeline flush)
//  ready_o   out  1     high in IDLE only
//  done_o    out  1     one-cycle pulse; result_o valid that cycle
//  result_o  out  XLEN  registered result; held until next acceptance
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ready_o=1, done_o=0, result_o=0, counter=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: start_i&~flush_i -> latch op, operand magnitudes, result signs, count=0; go BUSY.
//   BUSY: one radix-2 step per cycle (shift-add for mul, restoring shift-subtract for div);
//         count==XLEN-1 -> apply sign fixup/special cases, load result_o, go DONE.
//   DONE: done_o=1 for exactly this cycle; return to IDLE next edge.
//  Latency: acceptance at edge E -> done_o high in the cycle after edge E+XLEN (XLEN+1 cycles).
//  start_i while not ready_o: ignored, no queueing. done_o and start in same cycle: start ignored.
//  flush_i in any state: next state IDLE, no done_o, result_o keeps old value; flush beats start.
//  Multiply: 2*XLEN product of magnitudes; negate if sign(a)^sign(b) for signed operands.
//   mul=low XLEN; mulh=s*s high; mulhsu=a signed,b unsigned high; mulhu=u*u high.
//  Divide: unsigned restoring on magnitudes; quotient sign = sa^sb, remainder sign = sa.
//   b=0: quotient=all-ones (div/divu), remainder=a (rem/remu), overriding sign fixup.
//   div/rem with a=MIN_INT, b=-1: quotient=MIN_INT, remainder=0.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: on acceptance, if b_i==0 (div/rem ops) or a_i==0/b_i==0 (mul ops),
//   go IDLE->DONE directly with the architectural result; done_o in the next cycle (latency 1).
//  Undefined: every op takes exactly XLEN+1 cycles, including zero operands and div-by-zero.
// STRUCTURE
//  rv32i_types gains: muldiv_funct3_t enum (mul=000,mulh=001,mulhsu=010,mulhu=011,div=100,
//   divu=101,rem=110,remu=111), localparam funct7_muldiv=7'b0000001, muldiv_state_t enum.
//  Sub-module muldiv_step: combinational single iteration (shift-add / compare-subtract),
//   instantiated once; FSM, counter, sign fixup and special cases remain in this module.
// TESTING (XLEN=32)
//  mul 7*0xFFFFFFFD -> 0xFFFFFFEB; mulh 0xFFFFFFFF*0xFFFFFFFF -> 0; mulhu same -> 0xFFFFFFFE;
//   mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  div 0xFFFFFFF9/2 -> 0xFFFFFFFD; rem same -> 0xFFFFFFFF; divu 100/7 -> 14; remu -> 2.
//  divu 5/0 -> 0xFFFFFFFF, remu 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0.
//  Timing: accept at cycle 0 -> done_o only in cycle 33, ready_o low cycles 1-33;
//   start_i held during BUSY is not re-accepted; back-to-back op accepted in cycle 34.
//  flush_i in cycle 10 of a div -> ready_o=1 in cycle 11, no done_o; rst asserted mid-BUSY ->
//   outputs at reset values immediately, next start behaves normally.
//  MULDIV_EARLY_OUT_EN: divu 9/0 accepted cycle 0 -> done_o cycle 1, result 0xFFFFFFFF;
//   without macro same op -> done_o cycle 33.

Source files
------------

// File: rtl/rv32m_muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Holds the funct3 op encoding, the funct7 tag, the FSM state and op-class helpers.
package rv32m_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_funct3_t;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_t;

    function automatic logic is_div(muldiv_funct3_t f);
        return f[2];
    endfunction

    function automatic logic signed_a(muldiv_funct3_t f);
        return f inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic signed_b(muldiv_funct3_t f);
        return f inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the muldiv unit.
// master (EX): start_i, funct3_i, a_i, b_i, flush_i out; ready_o, done_o, result_o in.
interface rv32m_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            ready_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, a_i, b_i, flush_i,
        input  ready_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, a_i, b_i, flush_i,
        output ready_o, done_o, result_o
    );
endinterface

// File: rtl/rv32m_muldiv_unit_step.sv
// One combinational radix-2 iteration: shift-add multiply or restoring divide.
// Ports: is_div selects the op; hi/lo/opnd current state; hi_n/lo_n next state.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_n,
    output logic [XLEN-1:0] lo_n
);
    logic [XLEN:0] sum;
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;

    always_comb begin
        // mul: {hi,lo} is the partial product, lo LSB-first multiplier
        sum  = {1'b0, hi} + ({(XLEN+1){lo[0]}} & {1'b0, opnd});
        // div: hi is the partial remainder, lo shifts dividend out / quotient in
        sh   = {hi, lo[XLEN-1]};
        diff = sh - {1'b0, opnd};
        if (is_div) begin
            // hi < opnd always holds, so bit XLEN of diff is the borrow
            if (diff[XLEN]) begin
                hi_n = sh[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b0};
            end else begin
                hi_n = diff[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit, XLEN+1 cycles per op, flushable.
// Ports: clk, rst (async high), bus (slave: start/funct3/a/b/flush in, ready/done/result out).
// Define MULDIV_EARLY_OUT_EN to finish zero-operand and divide-by-zero ops in one cycle.
module rv32m_muldiv_unit
    import rv32m_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    rv32m_muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    muldiv_state_t   state;
    muldiv_funct3_t  op;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic            neg_q;
    logic            neg_r;
    logic            b_zero;
    logic            ready_r;
    logic            done_r;
    logic [XLEN-1:0] result_r;

    muldiv_funct3_t  f3;
    logic            sa_in;
    logic            sb_in;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    logic [XLEN-1:0]   hi_n;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin;

    assign f3    = muldiv_funct3_t'(bus.funct3_i);
    assign sa_in = signed_a(f3) & bus.a_i[XLEN-1];
    assign sb_in = signed_b(f3) & bus.b_i[XLEN-1];
    assign a_mag = sa_in ? -bus.a_i : bus.a_i;
    assign b_mag = sb_in ? -bus.b_i : bus.b_i;

`ifdef MULDIV_EARLY_OUT_EN
    logic            early;
    logic [XLEN-1:0] early_res;

    assign early = is_div(f3) ? (bus.b_i == '0)
                              : (bus.a_i == '0 || bus.b_i == '0);
    // rem/remu have funct3[1] set and return the dividend
    assign early_res = !is_div(f3) ? '0 : (f3[1] ? bus.a_i : '1);
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (is_div(op)),
        .hi     (hi),
        .lo     (lo),
        .opnd   (opnd),
        .hi_n   (hi_n),
        .lo_n   (lo_n)
    );

    // Sign fixup on the final step's output. MIN_INT/-1 falls out
    // naturally: |a|/1 = 0x80..0, negated stays 0x80..0, remainder 0.
    // With b=0 the remainder path shifts |a| into hi, so only the
    // quotient needs an explicit override.
    always_comb begin
        prod = {hi_n, lo_n};
        if (neg_q) prod = -prod;
        quo = b_zero ? '1 : (neg_q ? -lo_n : lo_n);
        rem = neg_r ? -hi_n : hi_n;
        fin = rem;
        unique case (op)
            OP_MUL:                       fin = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin = quo;
            OP_REM, OP_REMU:              fin = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op       <= OP_MUL;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            done_r <= 1'b0;
            if (bus.flush_i) begin
                state   <= ST_IDLE;
                ready_r <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.start_i) begin
                            op      <= f3;
                            count   <= '0;
                            hi      <= '0;
                            lo      <= is_div(f3) ? a_mag : b_mag;
                            opnd    <= is_div(f3) ? b_mag : a_mag;
                            neg_q   <= sa_in ^ sb_in;
                            neg_r   <= sa_in;
                            b_zero  <= (bus.b_i == '0);
                            ready_r <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                            if (early) begin
                                result_r <= early_res;
                                done_r   <= 1'b1;
                                state    <= ST_DONE;
                            end else begin
                                state <= ST_BUSY;
                            end
`else
                            state <= ST_BUSY;
`endif
                        end
                    end
                    ST_BUSY: begin
                        hi    <= hi_n;
                        lo    <= lo_n;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            result_r <= fin;
                            done_r   <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state   <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.ready_o  = ready_r;
    assign bus.done_o   = done_r;
    assign bus.result_o = result_r;
endmodule
